// File: rtl/spu_pkg.sv
// Shared widths, types and slot encoding for the SPU operand-forwarding stage.
package spu_pkg;

  localparam int DATA_W    = 128;
  localparam int REG_AW    = 7;
  localparam int FW_STAGES = 7;
  localparam int CNT_W     = 3;

  localparam int NUM_REGS  = 1 << REG_AW;
  localparam int FW_N      = FW_STAGES - 1;  // staging stages that can actually match
  localparam int NUM_SLOTS = 2;
  localparam int NUM_OPS   = 3;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] quad_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic {
    SLOT_EVEN = 1'b0,
    SLOT_ODD  = 1'b1
  } slot_e;

endpackage

// File: rtl/spu_fwd_mux.sv
// Priority select for one source operand: staging stage 1 (youngest) first, then wb, then RegTable.
module spu_fwd_mux
  import spu_pkg::*;
(
  input  reg_addr_t            i_src_addr,
  input  quad_t     [FW_N-1:0] i_ev_fw,
  input  reg_addr_t [FW_N-1:0] i_ev_fw_addr,
  input  logic      [FW_N-1:0] i_ev_fw_wr,
  input  quad_t     [FW_N-1:0] i_od_fw,
  input  reg_addr_t [FW_N-1:0] i_od_fw_addr,
  input  logic      [FW_N-1:0] i_od_fw_wr,
  input  quad_t                i_ev_wb,
  input  reg_addr_t            i_ev_wb_addr,
  input  logic                 i_ev_wb_wr,
  input  quad_t                i_od_wb,
  input  reg_addr_t            i_od_wb_addr,
  input  logic                 i_od_wb_wr,
  input  quad_t                i_rf_val,
  output quad_t                o_val
);

  quad_t w_val;

  // NOTE: blocking assignments in always_comb; the default comes first so no
  // latch is inferred, and the last matching assignment wins, so sources are
  // visited oldest to youngest (odd before even) to give the youngest, even-first priority.
  always_comb begin
    w_val = i_rf_val;
    if (i_od_wb_wr && i_od_wb_addr == i_src_addr) w_val = i_od_wb;
    if (i_ev_wb_wr && i_ev_wb_addr == i_src_addr) w_val = i_ev_wb;
    for (int k = FW_N - 1; k >= 0; k--) begin
      if (i_od_fw_wr[k] && i_od_fw_addr[k] == i_src_addr) w_val = i_od_fw[k];
      if (i_ev_fw_wr[k] && i_ev_fw_addr[k] == i_src_addr) w_val = i_ev_fw[k];
    end
  end

  assign o_val = w_val;

endmodule

// File: rtl/spu_operand_forward.sv
// RF/FWD stage: per-operand forwarding, latency scoreboard with stall, and the execute-entry register.
module spu_operand_forward
  import spu_pkg::*;
(
  input  logic                                        clk,
  input  logic                                        reset,
  input  quad_t     [FW_STAGES-1:0]                   ev_fw,
  input  reg_addr_t [FW_STAGES-1:0]                   ev_fw_addr,
  input  logic      [FW_STAGES-1:0]                   ev_fw_wr,
  input  quad_t                                       ev_wb,
  input  reg_addr_t                                   ev_wb_addr,
  input  logic                                        ev_wb_wr,
  input  quad_t     [FW_STAGES-1:0]                   od_fw,
  input  reg_addr_t [FW_STAGES-1:0]                   od_fw_addr,
  input  logic      [FW_STAGES-1:0]                   od_fw_wr,
  input  quad_t                                       od_wb,
  input  reg_addr_t                                   od_wb_addr,
  input  logic                                        od_wb_wr,
  input  reg_addr_t [NUM_SLOTS-1:0][NUM_OPS-1:0]      src_addr,
  input  logic      [NUM_SLOTS-1:0][NUM_OPS-1:0]      src_use,
  input  quad_t     [NUM_SLOTS-1:0][NUM_OPS-1:0]      rf_val,
  input  logic      [NUM_SLOTS-1:0]                   iss_valid,
  input  reg_addr_t [NUM_SLOTS-1:0]                   iss_rt,
  input  logic      [NUM_SLOTS-1:0]                   iss_wr,
  input  cnt_t      [NUM_SLOTS-1:0]                   iss_lat,
  input  logic                                        flush,
  output logic                                        stall,
  output quad_t     [NUM_SLOTS-1:0][NUM_OPS-1:0]      op_val,
  output logic      [NUM_SLOTS-1:0]                   op_valid
);

  cnt_t  r_cnt [NUM_REGS];
  quad_t [NUM_SLOTS-1:0][NUM_OPS-1:0] w_sel;
  logic  w_stall;
  logic  w_load_ev;
  logic  w_load_od;

  // Staging slot 0 is a hardwired zero stage and never takes part in matching.
  logic  w_unused_stage0;
  assign w_unused_stage0 = ^{ev_fw[0], ev_fw_addr[0], ev_fw_wr[0],
                             od_fw[0], od_fw_addr[0], od_fw_wr[0]};

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    for (genvar o = 0; o < NUM_OPS; o++) begin : g_op
      spu_fwd_mux u_mux (
        .i_src_addr   (src_addr[s][o]),
        .i_ev_fw      (ev_fw[FW_STAGES-1:1]),
        .i_ev_fw_addr (ev_fw_addr[FW_STAGES-1:1]),
        .i_ev_fw_wr   (ev_fw_wr[FW_STAGES-1:1]),
        .i_od_fw      (od_fw[FW_STAGES-1:1]),
        .i_od_fw_addr (od_fw_addr[FW_STAGES-1:1]),
        .i_od_fw_wr   (od_fw_wr[FW_STAGES-1:1]),
        .i_ev_wb      (ev_wb),
        .i_ev_wb_addr (ev_wb_addr),
        .i_ev_wb_wr   (ev_wb_wr),
        .i_od_wb      (od_wb),
        .i_od_wb_addr (od_wb_addr),
        .i_od_wb_wr   (od_wb_wr),
        .i_rf_val     (rf_val[s][o]),
        .o_val        (w_sel[s][o])
      );
    end
  end

  always_comb begin
    w_stall = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int o = 0; o < NUM_OPS; o++) begin
        if (iss_valid[s] && src_use[s][o] && r_cnt[src_addr[s][o]] != '0) w_stall = 1'b1;
      end
    end
  end

  assign stall     = w_stall;
  assign w_load_ev = iss_valid[SLOT_EVEN] & iss_wr[SLOT_EVEN] & ~w_stall;
  assign w_load_od = iss_valid[SLOT_ODD] & iss_wr[SLOT_ODD] & ~w_stall & ~flush;

  // NOTE: the scoreboard is a register array, not a RAM, so it is cleared on
  // reset; a stale nonzero count would otherwise stall the first reader forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r_cnt[r] != '0) r_cnt[r] <= r_cnt[r] - 1'b1;
      end
      // Later non-blocking writes win: loads beat the decrement, odd beats even.
      if (w_load_ev) r_cnt[iss_rt[SLOT_EVEN]] <= iss_lat[SLOT_EVEN];
      if (w_load_od) r_cnt[iss_rt[SLOT_ODD]]  <= iss_lat[SLOT_ODD];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_val   <= '0;
      op_valid <= '0;
    end else if (w_stall) begin
      op_valid <= '0;
    end else begin
      op_val   <= w_sel;
      op_valid <= iss_valid & {~flush, 1'b1};
    end
  end

endmodule

// File: tb/tb_spu_operand_forward.sv
// Directed self-checking bench for spu_operand_forward: forwarding priority, scoreboard stall, flush, reset.
module tb_spu_operand_forward;
  import spu_pkg::*;

  logic                                   clk = 1'b0;
  logic                                   reset;
  quad_t     [FW_STAGES-1:0]              ev_fw, od_fw;
  reg_addr_t [FW_STAGES-1:0]              ev_fw_addr, od_fw_addr;
  logic      [FW_STAGES-1:0]              ev_fw_wr, od_fw_wr;
  quad_t                                  ev_wb, od_wb;
  reg_addr_t                              ev_wb_addr, od_wb_addr;
  logic                                   ev_wb_wr, od_wb_wr;
  reg_addr_t [NUM_SLOTS-1:0][NUM_OPS-1:0] src_addr;
  logic      [NUM_SLOTS-1:0][NUM_OPS-1:0] src_use;
  quad_t     [NUM_SLOTS-1:0][NUM_OPS-1:0] rf_val;
  logic      [NUM_SLOTS-1:0]              iss_valid;
  reg_addr_t [NUM_SLOTS-1:0]              iss_rt;
  logic      [NUM_SLOTS-1:0]              iss_wr;
  cnt_t      [NUM_SLOTS-1:0]              iss_lat;
  logic                                   flush;
  logic                                   stall;
  quad_t     [NUM_SLOTS-1:0][NUM_OPS-1:0] op_val;
  logic      [NUM_SLOTS-1:0]              op_valid;

  int checks = 0;
  int errors = 0;
  int n_stall;

  localparam quad_t VAL_AA = {16{8'hAA}};
  localparam quad_t VAL_BB = {16{8'hBB}};

  always #5 clk = ~clk;

  spu_operand_forward dut (
    .clk(clk), .reset(reset),
    .ev_fw(ev_fw), .ev_fw_addr(ev_fw_addr), .ev_fw_wr(ev_fw_wr),
    .ev_wb(ev_wb), .ev_wb_addr(ev_wb_addr), .ev_wb_wr(ev_wb_wr),
    .od_fw(od_fw), .od_fw_addr(od_fw_addr), .od_fw_wr(od_fw_wr),
    .od_wb(od_wb), .od_wb_addr(od_wb_addr), .od_wb_wr(od_wb_wr),
    .src_addr(src_addr), .src_use(src_use), .rf_val(rf_val),
    .iss_valid(iss_valid), .iss_rt(iss_rt), .iss_wr(iss_wr), .iss_lat(iss_lat),
    .flush(flush), .stall(stall), .op_val(op_val), .op_valid(op_valid)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ev_fw = '0; ev_fw_addr = '0; ev_fw_wr = '0;
    od_fw = '0; od_fw_addr = '0; od_fw_wr = '0;
    ev_wb = '0; ev_wb_addr = '0; ev_wb_wr = 1'b0;
    od_wb = '0; od_wb_addr = '0; od_wb_wr = 1'b0;
    src_addr = '0; src_use = '0; rf_val = '0;
    iss_valid = '0; iss_rt = '0; iss_wr = '0; iss_lat = '0;
    flush = 1'b0;
  endtask

  // Counts consecutive stalled cycles with inputs held; bounded so a stuck stall cannot hang.
  task automatic count_stalls(output int n);
    n = 0;
    #1;
    while (stall === 1'b1 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("reset_op_valid", 128'(op_valid), 128'(2'b00));
    check("reset_op_val",   op_val[0][0], '0);
    check("reset_stall",    128'(stall), 128'(1'b0));
    reset = 1'b0;

    // No hazards: RegTable values pass straight through.
    iss_valid = 2'b11;
    src_addr[0][0] = 7'd1; src_addr[1][1] = 7'd2;
    src_use = '1;
    rf_val[0][0] = VAL_AA; rf_val[1][1] = VAL_BB;
    #1 check("nohaz_stall", 128'(stall), 128'(1'b0));
    tick();
    check("nohaz_ra",       op_val[0][0], VAL_AA);
    check("nohaz_odd_rb",   op_val[1][1], VAL_BB);
    check("nohaz_op_valid", 128'(op_valid), 128'(2'b11));

    // Priority: stage 2 beats stage 4, even beats odd at a stage, stage beats wb.
    src_addr[0][0] = 7'd5;
    ev_fw_addr[4] = 7'd5; ev_fw_wr[4] = 1'b1; ev_fw[4] = 128'h11;
    od_fw_addr[2] = 7'd5; od_fw_wr[2] = 1'b1; od_fw[2] = 128'h22;
    tick();
    check("prio_od_stage2", op_val[0][0], 128'h22);
    od_fw_wr[2] = 1'b0;
    tick();
    check("prio_ev_stage4", op_val[0][0], 128'h11);
    ev_fw_wr[4] = 1'b0;
    od_wb_addr = 7'd5; od_wb_wr = 1'b1; od_wb = 128'h33;
    tick();
    check("prio_od_wb", op_val[0][0], 128'h33);
    ev_wb_addr = 7'd5; ev_wb_wr = 1'b1; ev_wb = 128'h44;
    tick();
    check("prio_ev_wb_over_od_wb", op_val[0][0], 128'h44);
    ev_fw_addr[6] = 7'd5; ev_fw_wr[6] = 1'b1; ev_fw[6] = 128'h66;
    src_addr[1][2] = 7'd0;
    od_fw_addr[1] = 7'd0; od_fw_wr[1] = 1'b1; od_fw[1] = 128'h77;
    tick();
    check("prio_stage6_over_wb", op_val[0][0], 128'h66);
    check("reg0_forwarded",      op_val[1][2], 128'h77);

    // Scoreboard: r9 with latency 4, reader after one idle cycle stalls 3 cycles.
    clear_inputs();
    iss_valid = 2'b01; iss_wr = 2'b01; iss_rt[0] = 7'd9; iss_lat[0] = 3'd4;
    tick();
    clear_inputs();
    tick();
    iss_valid = 2'b11;
    src_addr[0][1] = 7'd9; src_use[0][1] = 1'b1;
    count_stalls(n_stall);
    check("sb_stall_cycles", 128'(n_stall), 128'(3));
    check("sb_bubble",       128'(op_valid), 128'(2'b00));
    ev_fw_addr[1] = 7'd9; ev_fw_wr[1] = 1'b1; ev_fw[1] = 128'h99;
    tick();
    check("sb_forward_stage1", op_val[0][1], 128'h99);
    check("sb_op_valid",       128'(op_valid), 128'(2'b11));

    // Flush: odd load of r7 is discarded and the odd slot becomes a bubble.
    clear_inputs();
    iss_valid = 2'b11; iss_wr = 2'b10; iss_rt[1] = 7'd7; iss_lat[1] = 3'd6; flush = 1'b1;
    tick();
    check("flush_op_valid", 128'(op_valid), 128'(2'b01));
    clear_inputs();
    iss_valid = 2'b11; src_addr[0][0] = 7'd7; src_use[0][0] = 1'b1;
    #1 check("flush_no_stall", 128'(stall), 128'(1'b0));
    tick();
    check("flush_reader_valid", 128'(op_valid), 128'(2'b11));

    // Collision: odd load (6) wins over even load (2) of r3.
    clear_inputs();
    iss_valid = 2'b11; iss_wr = 2'b11;
    iss_rt[0] = 7'd3; iss_lat[0] = 3'd2;
    iss_rt[1] = 7'd3; iss_lat[1] = 3'd6;
    tick();
    clear_inputs();
    tick();
    iss_valid = 2'b10; src_addr[1][1] = 7'd3; src_use[1][1] = 1'b1;
    count_stalls(n_stall);
    check("collision_stall_cycles", 128'(n_stall), 128'(5));
    tick();

    // Reload of a still-counting register takes the new latency over the decrement.
    clear_inputs();
    iss_valid = 2'b01; iss_wr = 2'b01; iss_rt[0] = 7'd3; iss_lat[0] = 3'd5;
    tick();
    iss_lat[0] = 3'd2;
    tick();
    clear_inputs();
    iss_valid = 2'b01; src_addr[0][2] = 7'd3; src_use[0][2] = 1'b1;
    count_stalls(n_stall);
    check("reload_stall_cycles", 128'(n_stall), 128'(2));
    tick();

    // Reset while stalled on a counter of 5.
    clear_inputs();
    iss_valid = 2'b01; iss_wr = 2'b01; iss_rt[0] = 7'd12; iss_lat[0] = 3'd6;
    tick();
    clear_inputs();
    tick();
    iss_valid = 2'b11; src_addr[0][0] = 7'd12; src_use[0][0] = 1'b1;
    #1 check("pre_reset_stall", 128'(stall), 128'(1'b1));
    reset = 1'b1;
    tick();
    check("reset_clears_stall",    128'(stall), 128'(1'b0));
    check("reset_clears_op_valid", 128'(op_valid), 128'(2'b00));
    reset = 1'b0;
    tick();
    check("post_reset_op_valid", 128'(op_valid), 128'(2'b11));
    check("post_reset_stall",    128'(stall), 128'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
